// File: rtl/block_requester.sv
// Initiator side of the cache block access handshake: one host request at a time,
// four-phase enable/ack exchange with a storage block, response held until accepted.
module block_requester #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [0:15] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        blk_enable,
  output logic        blk_write,
  output logic        blk_rst,
  output logic [15:0] blk_data_in,
  input  logic [15:0] blk_data_out,
  input  logic        blk_ack
);

  localparam logic [1:0]       OP_WR   = 2'b01;
  localparam logic [1:0]       OP_CLR  = 2'b10;
  localparam logic [1:0]       OP_ILL  = 2'b11;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ENABLE, RELEASE, RESP} state_t;

  state_t           state;
  logic             ack_p0;
  logic             ack_p1;
  logic [1:0]       primed;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             err;

  // primed keeps req_ready low until the synchronizer holds real ack samples again
  // after reset, so an ack still held by the block cannot look like a finished cycle.
  assign req_ready = (state == IDLE) && !ack_p1 && primed[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ack_p0      <= 1'b0;
      ack_p1      <= 1'b0;
      primed      <= 2'b00;
      cnt         <= '0;
      op_q        <= 2'b00;
      err         <= 1'b0;
      blk_enable  <= 1'b0;
      blk_write   <= 1'b0;
      blk_rst     <= 1'b0;
      blk_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      // ack synchronizer: ack_p1 is the only view of blk_ack the FSM uses
      ack_p0 <= blk_ack;
      ack_p1 <= ack_p0;
      primed <= {primed[0], 1'b1};

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q <= req_op;
            cnt  <= '0;
            err  <= 1'b0;
            if (req_op == OP_ILL) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= RESP;
            end else begin
              blk_enable  <= 1'b1;
              blk_write   <= (req_op == OP_WR);
              blk_rst     <= (req_op == OP_CLR);
              blk_data_in <= (req_op == OP_WR) ? req_data : 16'h0000;
              state       <= ENABLE;
            end
          end
        end

        ENABLE: begin
          cnt <= cnt + CNT_ONE;
          if (ack_p1) begin
            rsp_data    <= blk_data_out;
            blk_enable  <= 1'b0;
            blk_write   <= 1'b0;
            blk_rst     <= 1'b0;
            blk_data_in <= '0;
            cnt         <= '0;
            state       <= RELEASE;
          end else if (cnt == TO_LAST) begin
            err         <= 1'b1;
            rsp_data    <= '0;
            blk_enable  <= 1'b0;
            blk_write   <= 1'b0;
            blk_rst     <= 1'b0;
            blk_data_in <= '0;
            cnt         <= '0;
            state       <= RELEASE;
          end
        end

        RELEASE: begin
          cnt <= cnt + CNT_ONE;
          if (!ack_p1) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            if (err) rsp_data <= '0;
            state     <= RESP;
          end else if (cnt == TO_LAST) begin
            err       <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_requester.sv
// Bench for block_requester: table of directed transactions, multi-cycle corner
// sequences, and random transactions against a storage-level reference model.
module tb_block_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [0:15] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        blk_enable;
  logic        blk_write;
  logic        blk_rst;
  logic [15:0] blk_data_in;
  logic [15:0] blk_data_out;
  logic        blk_ack;

  block_requester #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .blk_enable(blk_enable), .blk_write(blk_write), .blk_rst(blk_rst),
    .blk_data_in(blk_data_in), .blk_data_out(blk_data_out), .blk_ack(blk_ack)
  );

  always #5 clk = ~clk;

  // Storage block model: mode 0 acks ack_delay cycles into enable, 1 never acks,
  // 2 ack driven directly by the test.
  logic [15:0] mem = 16'h0000;
  int          en_cnt = 0;
  int          mode = 0;
  int          ack_delay = 0;
  logic        manual_ack = 1'b0;

  always @(posedge clk) begin
    if (blk_enable) begin
      en_cnt <= en_cnt + 1;
      if (blk_write) mem <= blk_data_in;
      if (blk_rst)   mem <= 16'h0000;
    end else begin
      en_cnt <= 0;
    end
  end

  assign blk_data_out = mem;
  assign blk_ack = (mode == 2) ? manual_ack :
                   (mode == 1) ? 1'b0 : (blk_enable && (en_cnt >= ack_delay));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [15:0] data,
                        output int lat, output logic [15:0] rd, output logic er,
                        output int en_c, output int wr_c, output int rs_c,
                        output logic both, output logic din_bad);
    int guard;
    guard = 0;
    en_c = 0; wr_c = 0; rs_c = 0; both = 1'b0; din_bad = 1'b0;
    while (!req_ready && guard < 50) begin
      step;
      guard++;
    end
    check("req_ready_before_txn", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    step;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      if (blk_enable) en_c++;
      if (blk_write) wr_c++;
      if (blk_rst) rs_c++;
      if (blk_write && blk_rst) both = 1'b1;
      if (blk_write && blk_data_in !== data) din_bad = 1'b1;
      if (blk_enable && !blk_write && blk_data_in !== 16'h0000) din_bad = 1'b1;
      step;
      lat++;
    end
    rd = rsp_data;
    er = rsp_err;
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    step;
    check("rsp_valid_after_handshake", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_after_handshake", {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    int          dly;
    int          lat;
    logic [15:0] rdata;
    logic        err;
    int          en;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, en_c, wr_c, rs_c, guard;
    logic [15:0] rd, ref_mem, snap_d;
    logic        er, both, din_bad, snap_e, hold_bad, rst_bad;

    tbl[0] = '{2'b01, 16'hA5C3, 0, 7,  16'hA5C3, 1'b0, 3};
    tbl[1] = '{2'b00, 16'h0000, 0, 7,  16'hA5C3, 1'b0, 3};
    tbl[2] = '{2'b01, 16'hFFFF, 0, 7,  16'hFFFF, 1'b0, 3};
    tbl[3] = '{2'b10, 16'h0000, 0, 7,  16'h0000, 1'b0, 3};
    tbl[4] = '{2'b00, 16'h0000, 0, 7,  16'h0000, 1'b0, 3};
    tbl[5] = '{2'b11, 16'h1234, 0, 1,  16'h0000, 1'b1, 0};
    tbl[6] = '{2'b01, 16'h1234, 2, 9,  16'h1234, 1'b0, 5};
    tbl[7] = '{2'b00, 16'h0000, 5, 12, 16'h1234, 1'b0, 8};
    tbl[8] = '{2'b10, 16'h0000, 1, 8,  16'h0000, 1'b0, 4};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = 16'h0000; rsp_ready = 1'b1;
    step;
    step;
    check("reset_outputs",
          {15'd0, req_ready, rsp_valid, rsp_err, blk_enable, blk_write, blk_rst},
          32'd0);
    check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("reset_blk_data_in", {16'd0, blk_data_in}, 32'd0);
    rst = 1'b0;
    guard = 0;
    while (!req_ready && guard < 4) begin
      step;
      guard++;
    end
    check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      ack_delay = tbl[i].dly;
      do_txn(tbl[i].op, tbl[i].data, lat, rd, er, en_c, wr_c, rs_c, both, din_bad);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_rsp_data", i), {16'd0, rd}, {16'd0, tbl[i].rdata});
      check($sformatf("tbl%0d_rsp_err", i), {31'd0, er}, {31'd0, tbl[i].err});
      check($sformatf("tbl%0d_enable_cycles", i), en_c, tbl[i].en);
      check($sformatf("tbl%0d_write_cycles", i), wr_c, (tbl[i].op == 2'b01) ? tbl[i].en : 0);
      check($sformatf("tbl%0d_clear_cycles", i), rs_c, (tbl[i].op == 2'b10) ? tbl[i].en : 0);
      check($sformatf("tbl%0d_write_and_clear", i), {31'd0, both}, 32'd0);
      check($sformatf("tbl%0d_blk_data_in", i), {31'd0, din_bad}, 32'd0);
      finish_rsp;
    end

    // Timeout: block never acks
    ack_delay = 0;
    do_txn(2'b01, 16'h5A5A, lat, rd, er, en_c, wr_c, rs_c, both, din_bad);
    finish_rsp;
    mode = 1;
    do_txn(2'b00, 16'h0000, lat, rd, er, en_c, wr_c, rs_c, both, din_bad);
    check("timeout_enable_cycles", en_c, 16);
    check("timeout_latency", lat, 18);
    check("timeout_rsp_err", {31'd0, er}, 32'd1);
    check("timeout_rsp_data", {16'd0, rd}, 32'd0);
    finish_rsp;
    mode = 0;
    do_txn(2'b00, 16'h0000, lat, rd, er, en_c, wr_c, rs_c, both, din_bad);
    check("post_timeout_rsp_data", {16'd0, rd}, 32'h5A5A);
    check("post_timeout_rsp_err", {31'd0, er}, 32'd0);
    check("post_timeout_latency", lat, 7);
    finish_rsp;

    // Response held with rsp_ready low for 10 cycles
    rsp_ready = 1'b0;
    do_txn(2'b01, 16'h0F0F, lat, rd, er, en_c, wr_c, rs_c, both, din_bad);
    check("hold_latency", lat, 7);
    snap_d = rsp_data;
    snap_e = rsp_err;
    hold_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step;
      if (rsp_valid !== 1'b1 || rsp_data !== snap_d || rsp_err !== snap_e ||
          req_ready !== 1'b0 || blk_enable !== 1'b0) hold_bad = 1'b1;
    end
    check("hold_stable", {31'd0, hold_bad}, 32'd0);
    check("hold_rsp_data", {16'd0, snap_d}, 32'h0F0F);
    finish_rsp;
    check("hold_cleared_data", {16'd0, rsp_data}, 32'd0);

    // Reset in ENABLE while the block holds ack high
    mode = 2;
    manual_ack = 1'b0;
    guard = 0;
    while (!req_ready && guard < 10) begin
      step;
      guard++;
    end
    req_valid = 1'b1; req_op = 2'b01; req_data = 16'hBEEF;
    step;
    req_valid = 1'b0;
    manual_ack = 1'b1;
    check("rst_test_enable_up", {31'd0, blk_enable}, 32'd1);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("midrst_outputs",
          {15'd0, req_ready, rsp_valid, rsp_err, blk_enable, blk_write, blk_rst},
          32'd0);
    check("midrst_data", {rsp_data, blk_data_in}, 32'd0);
    rst_bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || blk_enable !== 1'b0) rst_bad = 1'b1;
    end
    check("midrst_ack_held_no_ready", {31'd0, rst_bad}, 32'd0);
    manual_ack = 1'b0;
    guard = 0;
    while (!req_ready && guard < 6) begin
      if (rsp_valid !== 1'b0) rst_bad = 1'b1;
      step;
      guard++;
    end
    check("midrst_ready_after_ack_low", {31'd0, req_ready}, 32'd1);
    check("midrst_no_stale_rsp", {31'd0, rst_bad}, 32'd0);
    mode = 0;

    // Random transactions against a storage-level reference model
    ack_delay = 0;
    do_txn(2'b01, 16'h0000, lat, rd, er, en_c, wr_c, rs_c, both, din_bad);
    finish_rsp;
    ref_mem = 16'h0000;
    for (int n = 0; n < 40; n++) begin
      int          sel, d;
      logic [1:0]  op;
      logic [15:0] data, exp_d;
      logic        exp_e;
      int          exp_lat;
      sel  = $urandom_range(0, 9);
      op   = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      data = 16'($urandom);
      d    = $urandom_range(0, 10);
      ack_delay = d;
      if (op == 2'b11) begin
        exp_d = 16'h0000; exp_e = 1'b1; exp_lat = 1;
      end else begin
        if (op == 2'b01) ref_mem = data;
        if (op == 2'b10) ref_mem = 16'h0000;
        exp_d = ref_mem; exp_e = 1'b0; exp_lat = 7 + d;
      end
      do_txn(op, data, lat, rd, er, en_c, wr_c, rs_c, both, din_bad);
      check($sformatf("rnd%0d_latency", n), lat, exp_lat);
      check($sformatf("rnd%0d_rsp_data", n), {16'd0, rd}, {16'd0, exp_d});
      check($sformatf("rnd%0d_rsp_err", n), {31'd0, er}, {31'd0, exp_e});
      check($sformatf("rnd%0d_write_and_clear", n), {31'd0, both}, 32'd0);
      finish_rsp;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
